// File: rtl/enet_reg_axil_slave.sv
// AXI4-Lite slave front-end of the ENET register block: decodes bus writes into
// one-cycle register write strobes and serves reads from the flattened register bus.
module enet_reg_axil_slave #(
    parameter int ADDR_W = 12,
    parameter int NREG   = 9
) (
    input  logic                 clk,
    input  logic                 enet_rst_n,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [ADDR_W-1:0]    s_awaddr,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    input  logic [31:0]          s_wdata,
    input  logic [3:0]           s_wstrb,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [1:0]           s_bresp,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [ADDR_W-1:0]    s_araddr,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [31:0]          s_rdata,
    output logic [1:0]           s_rresp,
    output logic [NREG-1:0]      reg_wen,
    output logic                 write_success,
    output logic [31:0]          reg_wdata,
    input  logic [32*NREG-1:0]   reg_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACC  = 3'd1,
        WR_RESP = 3'd2,
        RD_ACC  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte offsets of register indices 0..8 (EIR, EIMR, RDAR, TDAR, ECR, MMFR, MSCR, RCR, TCR).
    localparam logic [11:0] REG_OFFSET [0:8] = '{
        12'h004, 12'h008, 12'h010, 12'h014, 12'h024,
        12'h040, 12'h044, 12'h084, 12'h0C4
    };

    function automatic logic [NREG-1:0] decode_wen(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word_addr;
        word_addr  = {addr[ADDR_W-1:2], 2'b00};
        decode_wen = '0;
        for (int i = 0; i < NREG; i++) begin
            if (word_addr == ADDR_W'(REG_OFFSET[i])) begin
                decode_wen[i] = 1'b1;
            end else begin
                decode_wen[i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] select_rdata(input logic [NREG-1:0] hit,
                                                 input logic [32*NREG-1:0] bus);
        select_rdata = 32'h0000_0000;
        for (int i = 0; i < NREG; i++) begin
            if (hit[i]) begin
                select_rdata = bus[32*i +: 32];
            end else begin
                select_rdata = select_rdata;
            end
        end
    endfunction

    state_t            state_q, state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [NREG-1:0]   reg_wen_q, reg_wen_d;
    logic              write_success_q, write_success_d;
    logic [31:0]       reg_wdata_q, reg_wdata_d;
    logic              wr_err_q, wr_err_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;

    logic [NREG-1:0]   aw_hit_s;
    logic [NREG-1:0]   ar_hit_s;

    assign aw_hit_s = decode_wen(s_awaddr);
    assign ar_hit_s = decode_wen(araddr_q);

    // Next-state and next-output computation; outputs are all registered below.
    always_comb begin
        state_d         = state_q;
        awready_d       = 1'b0;
        wready_d        = 1'b0;
        arready_d       = 1'b0;
        reg_wen_d       = '0;
        write_success_d = 1'b0;
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        rvalid_d        = rvalid_q;
        rdata_d         = rdata_q;
        rresp_d         = rresp_q;
        reg_wdata_d     = reg_wdata_q;
        wr_err_d        = wr_err_q;
        araddr_d        = araddr_q;
        case (state_q)
            IDLE: begin
                // A write needs address and data together; it wins over a read.
                if (s_awvalid && s_wvalid) begin
                    state_d         = WR_ACC;
                    awready_d       = 1'b1;
                    wready_d        = 1'b1;
                    reg_wen_d       = aw_hit_s;
                    write_success_d = (s_wstrb == 4'hF) && (|aw_hit_s);
                    wr_err_d        = !((s_wstrb == 4'hF) && (|aw_hit_s));
                    reg_wdata_d     = s_wdata;
                end else if (s_arvalid) begin
                    state_d   = RD_ACC;
                    arready_d = 1'b1;
                    araddr_d  = s_araddr;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_ACC: begin
                state_d  = WR_RESP;
                bvalid_d = 1'b1;
                bresp_d  = wr_err_q ? RESP_SLVERR : RESP_OKAY;
            end
            WR_RESP: begin
                if (s_bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                    bresp_d  = RESP_OKAY;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_ACC: begin
                state_d  = RD_RESP;
                rvalid_d = 1'b1;
                rdata_d  = select_rdata(ar_hit_s, reg_rdata);
                rresp_d  = (|ar_hit_s) ? RESP_OKAY : RESP_SLVERR;
            end
            RD_RESP: begin
                // Read data stays frozen until the master takes it.
                if (s_rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    rresp_d  = RESP_OKAY;
                end else begin
                    state_d = RD_RESP;
                end
            end
            default: begin
                state_d  = IDLE;
                bvalid_d = 1'b0;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared only by the bus reset.
    always_ff @(posedge clk or negedge enet_rst_n) begin
        if (!enet_rst_n) begin
            state_q         <= IDLE;
            awready_q       <= 1'b0;
            wready_q        <= 1'b0;
            bvalid_q        <= 1'b0;
            bresp_q         <= 2'b00;
            arready_q       <= 1'b0;
            rvalid_q        <= 1'b0;
            rdata_q         <= 32'h0000_0000;
            rresp_q         <= 2'b00;
            reg_wen_q       <= '0;
            write_success_q <= 1'b0;
            reg_wdata_q     <= 32'h0000_0000;
            wr_err_q        <= 1'b0;
            araddr_q        <= '0;
        end else begin
            state_q         <= state_d;
            awready_q       <= awready_d;
            wready_q        <= wready_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            arready_q       <= arready_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            rresp_q         <= rresp_d;
            reg_wen_q       <= reg_wen_d;
            write_success_q <= write_success_d;
            reg_wdata_q     <= reg_wdata_d;
            wr_err_q        <= wr_err_d;
            araddr_q        <= araddr_d;
        end
    end

    assign s_awready     = awready_q;
    assign s_wready      = wready_q;
    assign s_bvalid      = bvalid_q;
    assign s_bresp       = bresp_q;
    assign s_arready     = arready_q;
    assign s_rvalid      = rvalid_q;
    assign s_rdata       = rdata_q;
    assign s_rresp       = rresp_q;
    assign reg_wen       = reg_wen_q;
    assign write_success = write_success_q;
    assign reg_wdata     = reg_wdata_q;

endmodule
